// File: rtl/spi_frame_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_slave
// Brief    : Oversampled SPI slave, FRAME_W-bit frames, any mode, optional byte swap.
// Revision : 1.0
// ============================================================================
module spi_frame_slave #(
  parameter int FRAME_W   = 16,
  parameter int CPOL      = 1,
  parameter int CPHA      = 1,
  parameter int BYTE_SWAP = 1,
  parameter int SYNC_STG  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spi_sck_i,
  input  logic               spi_mosi_i,
  input  logic               spi_ss_i,
  output logic               spi_miso_o,
  output logic               spi_miso_oe_o,
  input  logic [FRAME_W-1:0] tx_data_i,
  output logic [FRAME_W-1:0] rx_data_o,
  output logic               rx_valid_o,
  output logic               frame_err_o,
  output logic               busy_o
);

  localparam int               CNT_W       = $clog2(FRAME_W);
  localparam int               NBYTES      = FRAME_W / 8;
  localparam logic             SCK_IDLE    = (CPOL != 0);
  localparam logic             SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));
  localparam logic             LEAD_DRIVE  = (CPHA == 0);
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(FRAME_W - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [SYNC_STG-1:0] sck_sync_q,  sck_sync_d;
  logic [SYNC_STG-1:0] ss_sync_q,   ss_sync_d;
  logic [SYNC_STG-1:0] mosi_sync_q, mosi_sync_d;
  logic                sck_prev_q,  sck_prev_d;
  logic                ss_prev_q,   ss_prev_d;

  logic [1:0]         state_q,     state_d;
  logic [FRAME_W-1:0] shift_tx_q,  shift_tx_d;
  logic [FRAME_W-2:0] shift_rx_q,  shift_rx_d;
  logic [CNT_W-1:0]   bitcnt_q,    bitcnt_d;
  logic [FRAME_W-1:0] rx_data_q,   rx_data_d;
  logic               rx_valid_q,  rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               miso_q,      miso_d;
  logic               miso_oe_q,   miso_oe_d;

  logic w_sck, w_ss, w_mosi;
  logic w_sck_rise, w_sck_fall, w_sample_edge, w_launch_edge;
  logic w_ss_fall, w_ss_rise, w_last_sample;
  logic [FRAME_W-1:0] w_tx_wire, w_rx_word, w_rx_logical;

  // Edges are taken between the last synchroniser stage and one extra flop.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STG-2:0],  spi_sck_i};
    ss_sync_d   = {ss_sync_q[SYNC_STG-2:0],   spi_ss_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STG-2:0], spi_mosi_i};
    sck_prev_d  = sck_sync_q[SYNC_STG-1];
    ss_prev_d   = ss_sync_q[SYNC_STG-1];
  end

  assign w_sck  = sck_sync_q[SYNC_STG-1];
  assign w_ss   = ss_sync_q[SYNC_STG-1];
  assign w_mosi = mosi_sync_q[SYNC_STG-1];

  assign w_sck_rise    = w_sck & ~sck_prev_q;
  assign w_sck_fall    = ~w_sck & sck_prev_q;
  assign w_sample_edge = SAMPLE_RISE ? w_sck_rise : w_sck_fall;
  assign w_launch_edge = SAMPLE_RISE ? w_sck_fall : w_sck_rise;
  assign w_ss_fall     = ~w_ss & ss_prev_q;
  assign w_ss_rise     = w_ss & ~ss_prev_q;
  assign w_last_sample = w_sample_edge && (bitcnt_q == LAST_BIT);

  assign w_rx_word = {shift_rx_q, w_mosi};

  generate
    if (BYTE_SWAP != 0) begin : g_swap
      // Wire order carries logical byte 0 first; the mapping is its own inverse.
      for (genvar i = 0; i < NBYTES; i++) begin : g_byte
        assign w_tx_wire[FRAME_W-1-8*i -: 8]  = tx_data_i[8*i +: 8];
        assign w_rx_logical[8*i +: 8]         = w_rx_word[FRAME_W-1-8*i -: 8];
      end
    end else begin : g_noswap
      assign w_tx_wire    = tx_data_i;
      assign w_rx_logical = w_rx_word;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    shift_tx_d  = shift_tx_q;
    shift_rx_d  = shift_rx_q;
    bitcnt_d    = bitcnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;

    case (state_q)
      ST_IDLE: begin
        if (w_ss_fall) begin
          state_d   = ST_ACTIVE;
          bitcnt_d  = '0;
          miso_oe_d = 1'b1;
          if (LEAD_DRIVE) begin
            miso_d     = w_tx_wire[FRAME_W-1];
            shift_tx_d = {w_tx_wire[FRAME_W-2:0], 1'b0};
          end else begin
            shift_tx_d = w_tx_wire;
          end
        end
      end

      ST_ACTIVE: begin
        if (w_sample_edge) begin
          shift_rx_d = w_rx_word[FRAME_W-2:0];
          bitcnt_d   = bitcnt_q + CNT_W'(1);
          if (bitcnt_q == LAST_BIT) begin
            rx_data_d  = w_rx_logical;
            rx_valid_d = 1'b1;
            state_d    = ST_DONE;
          end
        end else if (w_launch_edge) begin
          miso_d     = shift_tx_q[FRAME_W-1];
          shift_tx_d = {shift_tx_q[FRAME_W-2:0], 1'b0};
        end
        // A release coinciding with the final sample still completes the frame.
        if (w_ss_rise) begin
          state_d     = ST_IDLE;
          miso_oe_d   = 1'b0;
          miso_d      = 1'b0;
          frame_err_d = ~w_last_sample;
        end
      end

      ST_DONE: begin
        if (w_ss_rise) begin
          state_d   = ST_IDLE;
          miso_oe_d = 1'b0;
          miso_d    = 1'b0;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        miso_oe_d = 1'b0;
        miso_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= {SYNC_STG{SCK_IDLE}};
      ss_sync_q   <= {SYNC_STG{1'b1}};
      mosi_sync_q <= '0;
      sck_prev_q  <= SCK_IDLE;
      ss_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      shift_tx_q  <= '0;
      shift_rx_q  <= '0;
      bitcnt_q    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      ss_prev_q   <= ss_prev_d;
      state_q     <= state_d;
      shift_tx_q  <= shift_tx_d;
      shift_rx_q  <= shift_rx_d;
      bitcnt_q    <= bitcnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = miso_oe_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign frame_err_o   = frame_err_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_frame_slave
// Brief    : Directed bench: mode-3/16-bit/byte-swap slave and mode-0/32-bit slave.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_spi_frame_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        sck_a, mosi_a, ss_a, miso_a, oe_a, vld_a, err_a, busy_a;
  logic [15:0] tx_a, rx_a;
  logic        sck_b, mosi_b, ss_b, miso_b, oe_b, vld_b, err_b, busy_b;
  logic [31:0] tx_b, rx_b;

  spi_frame_slave #(.FRAME_W(16), .CPOL(1), .CPHA(1), .BYTE_SWAP(1), .SYNC_STG(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .spi_sck_i(sck_a), .spi_mosi_i(mosi_a), .spi_ss_i(ss_a),
    .spi_miso_o(miso_a), .spi_miso_oe_o(oe_a), .tx_data_i(tx_a), .rx_data_o(rx_a),
    .rx_valid_o(vld_a), .frame_err_o(err_a), .busy_o(busy_a));

  spi_frame_slave #(.FRAME_W(32), .CPOL(0), .CPHA(0), .BYTE_SWAP(0), .SYNC_STG(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .spi_sck_i(sck_b), .spi_mosi_i(mosi_b), .spi_ss_i(ss_b),
    .spi_miso_o(miso_b), .spi_miso_oe_o(oe_b), .tx_data_i(tx_b), .rx_data_o(rx_b),
    .rx_valid_o(vld_b), .frame_err_o(err_b), .busy_o(busy_b));

  int n_pass = 0, n_total = 0;
  int vld_cnt_a = 0, err_cnt_a = 0, vld_cnt_b = 0, err_cnt_b = 0;
  logic [15:0] rx_log_a [0:7];
  logic [63:0] miso_cap;

  // Pulse monitor: counts high cycles, so a stretched pulse shows up as extra counts.
  always @(negedge clk) begin
    if (vld_a) begin
      if (vld_cnt_a < 8) rx_log_a[vld_cnt_a] = rx_a;
      vld_cnt_a++;
    end
    if (err_a) err_cnt_a++;
    if (vld_b) vld_cnt_b++;
    if (err_b) err_cnt_b++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  task automatic ss_set(input bit sel, input logic v);
    @(negedge clk);
    if (sel) ss_b = v; else ss_a = v;
  endtask

  // Sends the first n bits (MSB first) of a total-bit wire word; sel 0 = mode 3, sel 1 = mode 0.
  task automatic xfer(input bit sel, input int total, input int n, input logic [63:0] w);
    logic b;
    miso_cap = '0;
    for (int i = 0; i < n; i++) begin
      b = w[total-1-i];
      if (!sel) begin
        sck_a = 1'b0; mosi_a = b; half();
        miso_cap = {miso_cap[62:0], miso_a};
        sck_a = 1'b1; half();
      end else begin
        mosi_b = b; half();
        miso_cap = {miso_cap[62:0], miso_b};
        sck_b = 1'b1; half();
        sck_b = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sck_a = 1'b1; ss_a = 1'b1; mosi_a = 1'b0; tx_a = '0;
    sck_b = 1'b0; ss_b = 1'b1; mosi_b = 1'b0; tx_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    check("rst_miso", miso_a, 0);
    check("rst_oe", oe_a, 0);
    check("rst_rx", rx_a, 0);
    check("rst_valid", vld_a, 0);
    check("rst_err", err_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_rx_b", rx_b, 0);

    // 16'h2001 travels as 0x01,0x20; tx BEEF travels as 0xEF,0xBE
    tx_a = 16'hBEEF;
    ss_set(0, 1'b0); half();
    check("t1_oe_active", oe_a, 1);
    xfer(0, 16, 16, 64'h0120);
    check("t1_busy_done", busy_a, 1);
    ss_set(0, 1'b1); repeat (6) @(negedge clk);
    check("t1_vld_cnt", vld_cnt_a, 1);
    check("t1_rx", rx_a, 16'h2001);
    check("t1_miso", miso_cap[15:0], 16'hEFBE);
    check("t1_err_cnt", err_cnt_a, 0);
    check("t1_oe_idle", oe_a, 0);
    check("t1_busy_idle", busy_a, 0);
    check("t1_miso_idle", miso_a, 0);

    tx_a = 16'hA55A;
    ss_set(0, 1'b0); half();
    xfer(0, 16, 16, 64'h0100);
    ss_set(0, 1'b1); repeat (6) @(negedge clk);
    check("t2_vld_cnt", vld_cnt_a, 2);
    check("t2_rx", rx_a, 16'h0001);
    check("t2_miso_byte0", miso_cap[15:8], 8'h5A);
    check("t2_miso_byte1", miso_cap[7:0], 8'hA5);

    ss_set(0, 1'b0); half();
    xfer(0, 16, 7, 64'h1234);
    ss_set(0, 1'b1); repeat (6) @(negedge clk);
    check("t3_err_cnt", err_cnt_a, 1);
    check("t3_vld_cnt", vld_cnt_a, 2);
    check("t3_rx_kept", rx_a, 16'h0001);
    check("t3_busy", busy_a, 0);

    // back-to-back with SS high for 3 clk
    ss_set(0, 1'b0); half();
    xfer(0, 16, 16, 64'h0713);
    ss_set(0, 1'b1); repeat (2) @(negedge clk);
    ss_set(0, 1'b0); half();
    xfer(0, 16, 16, 64'h0111);
    ss_set(0, 1'b1); repeat (6) @(negedge clk);
    check("t4_vld_cnt", vld_cnt_a, 4);
    check("t4_first", rx_log_a[2], 16'h1307);
    check("t4_second", rx_log_a[3], 16'h1101);
    check("t4_err_cnt", err_cnt_a, 1);

    // reset mid-frame after 9 bits of 16'h1200
    ss_set(0, 1'b0); half();
    xfer(0, 16, 9, 64'h0012);
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_rst_rx", rx_a, 0);
    check("t5_rst_oe", oe_a, 0);
    check("t5_rst_busy", busy_a, 0);
    check("t5_rst_miso", miso_a, 0);
    ss_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_no_vld", vld_cnt_a, 4);
    check("t5_no_err", err_cnt_a, 1);
    ss_set(0, 1'b0); half();
    xfer(0, 16, 16, 64'h0110);
    ss_set(0, 1'b1); repeat (6) @(negedge clk);
    check("t5_vld_cnt", vld_cnt_a, 5);
    check("t5_rx", rx_a, 16'h1001);

    // mode 0, 32-bit, no swap
    tx_b = 32'h12345678;
    ss_set(1, 1'b0); half();
    xfer(1, 32, 32, 64'hDEADBEEF);
    ss_set(1, 1'b1); repeat (6) @(negedge clk);
    check("t6_vld_cnt", vld_cnt_b, 1);
    check("t6_rx", rx_b, 32'hDEADBEEF);
    check("t6_miso", miso_cap[31:0], 32'h12345678);
    check("t6_err_cnt", err_cnt_b, 0);
    check("t6_oe_idle", oe_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
